// File: rtl/svc_axil_arbiter_pkg.sv
// svc_axil_arbiter_pkg: shared operation type for the AXI-Lite arbiter
package svc_axil_arbiter_pkg;
  typedef enum logic {OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/svc_rr_arbiter.sv
// svc_rr_arbiter: round-robin requester select; the pointer moves past each granted index
module svc_rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int IW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] i_req,
  input  logic             i_advance,
  output logic             o_grant_valid,
  output logic [IW-1:0]    o_grant_idx
);
  logic [IW-1:0] r_ptr;
  always_comb begin
    o_grant_valid = |i_req;
    o_grant_idx   = r_ptr;
    for (int k = NUM_M - 1; k >= 0; k--)
      if (i_req[(int'(r_ptr) + k) % NUM_M]) o_grant_idx = IW'((int'(r_ptr) + k) % NUM_M);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= '0;
    else if (i_advance) r_ptr <= (o_grant_idx == IW'(NUM_M - 1)) ? '0 : o_grant_idx + 1'b1;
endmodule

// File: rtl/svc_axil_arbiter.sv
// svc_axil_arbiter: shares one AXI-Lite manager port among NUM_M requesters,
// round-robin, with a single transaction outstanding at a time.
module svc_axil_arbiter
  import svc_axil_arbiter_pkg::*;
#(
  parameter int NUM_M           = 2,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
  parameter int IW              = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_M*AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [NUM_M-1:0]                   s_axil_awvalid,
  output logic [NUM_M-1:0]                   s_axil_awready,
  input  logic [NUM_M*AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [NUM_M*AXIL_STRB_WIDTH-1:0]   s_axil_wstrb,
  input  logic [NUM_M-1:0]                   s_axil_wvalid,
  output logic [NUM_M-1:0]                   s_axil_wready,
  output logic [1:0]                         s_axil_bresp,
  output logic [NUM_M-1:0]                   s_axil_bvalid,
  input  logic [NUM_M-1:0]                   s_axil_bready,
  input  logic [NUM_M*AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [NUM_M-1:0]                   s_axil_arvalid,
  output logic [NUM_M-1:0]                   s_axil_arready,
  output logic [AXIL_DATA_WIDTH-1:0]         s_axil_rdata,
  output logic [1:0]                         s_axil_rresp,
  output logic [NUM_M-1:0]                   s_axil_rvalid,
  input  logic [NUM_M-1:0]                   s_axil_rready,
  output logic [AXIL_ADDR_WIDTH-1:0]         m_axil_awaddr,
  output logic                               m_axil_awvalid,
  input  logic                               m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0]         m_axil_wdata,
  output logic [AXIL_STRB_WIDTH-1:0]         m_axil_wstrb,
  output logic                               m_axil_wvalid,
  input  logic                               m_axil_wready,
  input  logic [1:0]                         m_axil_bresp,
  input  logic                               m_axil_bvalid,
  output logic                               m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0]         m_axil_araddr,
  output logic                               m_axil_arvalid,
  input  logic                               m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]         m_axil_rdata,
  input  logic [1:0]                         m_axil_rresp,
  input  logic                               m_axil_rvalid,
  output logic                               m_axil_rready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
  state_t r_state, w_next;
  logic [NUM_M-1:0] w_req, w_g_oh, w_grant_oh;
  logic [IW-1:0] w_g, r_grant;
  logic w_gv, w_take, w_aw_left, w_w_left, w_rd_done, w_wr_done;
  logic r_arvalid, r_awvalid, r_wvalid;
  logic [AXIL_ADDR_WIDTH-1:0] r_araddr, r_awaddr;
  logic [AXIL_DATA_WIDTH-1:0] r_wdata;
  logic [AXIL_STRB_WIDTH-1:0] r_wstrb;
  op_t r_last_op, w_op;
  assign w_req = s_axil_arvalid | (s_axil_awvalid & s_axil_wvalid);
  svc_rr_arbiter #(.NUM_M(NUM_M), .IW(IW)) u_rr (
    .clk(clk), .rst(rst), .i_req(w_req), .i_advance(w_take),
    .o_grant_valid(w_gv), .o_grant_idx(w_g)
  );
  // Grant readies are combinational; gating on rst keeps them low during reset
  assign w_take = !rst && r_state == IDLE && w_gv;
  assign w_op = (s_axil_awvalid[w_g] && s_axil_wvalid[w_g] &&
                 (!s_axil_arvalid[w_g] || r_last_op == OP_READ)) ? OP_WRITE : OP_READ;
  assign w_g_oh     = NUM_M'(1) << w_g;
  assign w_grant_oh = NUM_M'(1) << r_grant;
  assign s_axil_arready = (w_take && w_op == OP_READ) ? w_g_oh : '0;
  assign s_axil_awready = (w_take && w_op == OP_WRITE) ? w_g_oh : '0;
  assign s_axil_wready  = s_axil_awready;
  assign s_axil_rvalid  = (r_state == RD_DATA && m_axil_rvalid) ? w_grant_oh : '0;
  assign s_axil_bvalid  = (r_state == WR_RESP && m_axil_bvalid) ? w_grant_oh : '0;
  assign m_axil_rready  = r_state == RD_DATA && s_axil_rready[r_grant];
  assign m_axil_bready  = r_state == WR_RESP && s_axil_bready[r_grant];
  assign s_axil_rdata   = m_axil_rdata;
  assign s_axil_rresp   = m_axil_rresp;
  assign s_axil_bresp   = m_axil_bresp;
  assign m_axil_arvalid = r_arvalid;
  assign m_axil_araddr  = r_araddr;
  assign m_axil_awvalid = r_awvalid;
  assign m_axil_awaddr  = r_awaddr;
  assign m_axil_wvalid  = r_wvalid;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign w_aw_left = r_awvalid && !m_axil_awready;
  assign w_w_left  = r_wvalid && !m_axil_wready;
  assign w_rd_done = m_axil_rvalid && m_axil_rready;
  assign w_wr_done = m_axil_bvalid && m_axil_bready;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_take) w_next = (w_op == OP_WRITE) ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (m_axil_arready) w_next = RD_DATA;
      RD_DATA: if (w_rd_done) w_next = IDLE;
      WR_ADDR: if (!w_aw_left && !w_w_left) w_next = WR_RESP;
      WR_RESP: if (w_wr_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_grant   <= '0;
      r_last_op <= OP_READ;
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_araddr  <= '0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (w_take) begin
        r_grant   <= w_g;
        r_araddr  <= s_axil_araddr[w_g*AXIL_ADDR_WIDTH +: AXIL_ADDR_WIDTH];
        r_awaddr  <= s_axil_awaddr[w_g*AXIL_ADDR_WIDTH +: AXIL_ADDR_WIDTH];
        r_wdata   <= s_axil_wdata[w_g*AXIL_DATA_WIDTH +: AXIL_DATA_WIDTH];
        r_wstrb   <= s_axil_wstrb[w_g*AXIL_STRB_WIDTH +: AXIL_STRB_WIDTH];
        r_arvalid <= w_op == OP_READ;
        r_awvalid <= w_op == OP_WRITE;
        r_wvalid  <= w_op == OP_WRITE;
      end else begin
        r_arvalid <= r_arvalid && !m_axil_arready;
        r_awvalid <= w_aw_left;
        r_wvalid  <= w_w_left;
      end
      if (r_state == RD_DATA && w_rd_done) r_last_op <= OP_READ;
      if (r_state == WR_RESP && w_wr_done) r_last_op <= OP_WRITE;
    end
endmodule

// File: tb/tb_svc_axil_arbiter.sv
// tb_svc_axil_arbiter: directed checks of grant order, op alternation, handshakes and reset
module tb_svc_axil_arbiter;
  localparam int N = 2, AW = 32, DW = 32, SW = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [N*AW-1:0] s_axil_awaddr, s_axil_araddr;
  logic [N*DW-1:0] s_axil_wdata;
  logic [N*SW-1:0] s_axil_wstrb;
  logic [N-1:0] s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [N-1:0] s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic [N-1:0] s_axil_rvalid, s_axil_rready;
  logic [1:0] s_axil_bresp, s_axil_rresp, m_axil_bresp, m_axil_rresp;
  logic [DW-1:0] s_axil_rdata, m_axil_wdata, m_axil_rdata;
  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [SW-1:0] m_axil_wstrb;
  logic m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic m_axil_rvalid, m_axil_rready;

  svc_axil_arbiter #(.NUM_M(N), .AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb), .m_axil_wvalid(m_axil_wvalid),
    .m_axil_wready(m_axil_wready), .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready), .m_axil_araddr(m_axil_araddr), .m_axil_arvalid(m_axil_arvalid),
    .m_axil_arready(m_axil_arready), .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  // Requesters: each keeps valid high while issued count exceeds accepted count
  int rd_req[N], rd_done[N], wr_req[N], wr_done[N];
  logic [AW-1:0] ar_a[N], aw_a[N];
  logic [DW-1:0] w_d[N];
  logic [SW-1:0] w_s[N];
  always_comb begin
    s_axil_arvalid = '0;
    s_axil_awvalid = '0;
    s_axil_wvalid  = '0;
    s_axil_araddr  = '0;
    s_axil_awaddr  = '0;
    s_axil_wdata   = '0;
    s_axil_wstrb   = '0;
    for (int i = 0; i < N; i++) begin
      s_axil_arvalid[i] = rd_req[i] != rd_done[i];
      s_axil_awvalid[i] = wr_req[i] != wr_done[i];
      s_axil_wvalid[i]  = wr_req[i] != wr_done[i];
      s_axil_araddr[i*AW +: AW] = ar_a[i];
      s_axil_awaddr[i*AW +: AW] = aw_a[i];
      s_axil_wdata[i*DW +: DW]  = w_d[i];
      s_axil_wstrb[i*SW +: SW]  = w_s[i];
    end
  end

  int log_idx[$];
  bit log_wr[$];
  logic outst;
  int overlap_err = 0, bready_err = 0;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (s_axil_arready[i]) begin
        rd_done[i] <= rd_done[i] + 1;
        log_idx.push_back(i);
        log_wr.push_back(1'b0);
      end
      if (s_axil_awready[i]) begin
        wr_done[i] <= wr_done[i] + 1;
        log_idx.push_back(i);
        log_wr.push_back(1'b1);
      end
    end
    if (m_axil_bready && (m_axil_awvalid || m_axil_wvalid)) bready_err <= bready_err + 1;
  end
  always @(posedge clk or posedge rst)
    if (rst) outst <= 1'b0;
    else begin
      if ((|s_axil_arready || |s_axil_awready) && outst) overlap_err <= overlap_err + 1;
      if (|s_axil_arready || |s_axil_awready) outst <= 1'b1;
      else if (|(s_axil_rvalid & s_axil_rready) || |(s_axil_bvalid & s_axil_bready)) outst <= 1'b0;
    end

  // Subordinate: AR always ready, read data one cycle later; AW ready after aw_delay waits
  int aw_delay = 0, aw_cnt;
  logic aw_got, w_got;
  logic [DW-1:0] sub_rdata;
  assign m_axil_arready = 1'b1;
  assign m_axil_wready  = 1'b1;
  assign m_axil_awready = m_axil_awvalid && aw_cnt >= aw_delay;
  assign m_axil_rresp   = 2'b00;
  assign m_axil_bresp   = 2'b00;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_axil_rvalid <= 1'b0;
      m_axil_bvalid <= 1'b0;
      m_axil_rdata  <= '0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      aw_cnt <= 0;
    end else begin
      if (m_axil_arvalid && m_axil_arready) begin
        m_axil_rvalid <= 1'b1;
        m_axil_rdata  <= sub_rdata;
      end else if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 1'b0;
      aw_cnt <= (m_axil_awvalid && !m_axil_awready) ? aw_cnt + 1 : 0;
      if ((aw_got || (m_axil_awvalid && m_axil_awready)) && (w_got || (m_axil_wvalid && m_axil_wready))) begin
        m_axil_bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (m_axil_awvalid && m_axil_awready) aw_got <= 1'b1;
        if (m_axil_wvalid && m_axil_wready) w_got <= 1'b1;
        if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
      end
    end

  logic [14:0] hs_all;
  assign hs_all = {m_axil_arvalid, m_axil_awvalid, m_axil_wvalid, m_axil_rready, m_axil_bready,
                   s_axil_arready, s_axil_awready, s_axil_wready, s_axil_rvalid, s_axil_bvalid};

  int n_checks = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit all_done();
    bit d = 1'b1;
    for (int i = 0; i < N; i++) d &= (rd_req[i] == rd_done[i]) && (wr_req[i] == wr_done[i]);
    return d && !outst;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (n < 300 && !all_done()) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < 300, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] pack_idx();
    logic [7:0] v = '0;
    foreach (log_idx[k]) if (k < 8) v[k] = log_idx[k] == 1;
    return v;
  endfunction

  function automatic logic [7:0] pack_wr();
    logic [7:0] v = '0;
    foreach (log_wr[k]) if (k < 8) v[k] = log_wr[k];
    return v;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      ar_a[i] = '0;
      aw_a[i] = '0;
      w_d[i]  = '0;
      w_s[i]  = '0;
    end
    s_axil_rready = '1;
    s_axil_bready = '1;
    sub_rdata = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check("reset_handshakes", hs_all, '0);
    rst = 1'b0;
    @(negedge clk);
    // single read from requester 0
    ar_a[0] = 32'h10;
    rd_req[0] = 1;
    #1;
    for (int n = 0; n < 20 && !s_axil_arready[0]; n++) @(negedge clk);
    check("t1_arready", s_axil_arready, 2'b01);
    check("t1_arvalid_same_cycle", m_axil_arvalid, 1'b0);
    @(negedge clk);
    check("t1_arvalid_next", m_axil_arvalid, 1'b1);
    check("t1_araddr", m_axil_araddr, 32'h10);
    for (int n = 0; n < 20 && !s_axil_rvalid[0]; n++) @(negedge clk);
    check("t1_rvalid", s_axil_rvalid, 2'b01);
    check("t1_rdata", s_axil_rdata, 32'hDEADBEEF);
    check("t1_rresp", s_axil_rresp, 2'b00);
    wait_idle("t1_done");
    // single write from requester 1
    aw_a[1] = 32'h20;
    w_d[1]  = 32'h1234;
    w_s[1]  = 4'hF;
    wr_req[1] = 1;
    #1;
    for (int n = 0; n < 20 && !m_axil_awvalid; n++) @(negedge clk);
    check("t2_awaddr", m_axil_awaddr, 32'h20);
    check("t2_wdata", m_axil_wdata, 32'h1234);
    check("t2_wstrb", m_axil_wstrb, 4'hF);
    for (int n = 0; n < 20 && !(|s_axil_bvalid); n++) @(negedge clk);
    check("t2_bvalid", s_axil_bvalid, 2'b10);
    check("t2_bresp", s_axil_bresp, 2'b00);
    wait_idle("t2_done");
    // both requesters stream reads: grants alternate starting at 0
    log_idx.delete();
    log_wr.delete();
    rd_req[0] += 4;
    rd_req[1] += 4;
    wait_idle("t3_done");
    check("t3_count", log_idx.size(), 8);
    check("t3_order", pack_idx(), 8'b1010_1010);
    // requester 0 holds read and write: ops alternate starting with write
    log_idx.delete();
    log_wr.delete();
    aw_a[0] = 32'h30;
    w_d[0]  = 32'h55AA;
    w_s[0]  = 4'h3;
    rd_req[0] += 3;
    wr_req[0] += 3;
    wait_idle("t4_done");
    check("t4_count", log_idx.size(), 6);
    check("t4_ops", pack_wr(), 8'b0001_0101);
    check("t4_idx", pack_idx(), 8'b0);
    // slow AW: no bready and no second grant until the write completes
    log_idx.delete();
    log_wr.delete();
    aw_delay = 3;
    wr_req[1] += 1;
    rd_req[0] += 1;
    #1;
    for (int n = 0; n < 20 && !m_axil_awvalid; n++) @(negedge clk);
    check("t5_wvalid_first", m_axil_wvalid, 1'b1);
    @(negedge clk);
    check("t5_wvalid_cleared", m_axil_wvalid, 1'b0);
    check("t5_awvalid_held", m_axil_awvalid, 1'b1);
    check("t5_bready_low", m_axil_bready, 1'b0);
    wait_idle("t5_done");
    check("t5_order", {log_idx.size(), pack_idx(), pack_wr()}, {32'd2, 8'b01, 8'b01});
    check("t5_overlap", overlap_err, 0);
    check("t5_bready_early", bready_err, 0);
    aw_delay = 0;
    // reset while requester 0 waits in read-data
    s_axil_rready = '0;
    rd_req[0] += 1;
    #1;
    for (int n = 0; n < 20 && !s_axil_rvalid[0]; n++) @(negedge clk);
    check("t6_rvalid_held", s_axil_rvalid, 2'b01);
    rst = 1'b1;
    #1;
    check("t6_reset_handshakes", hs_all, '0);
    rd_req[0] += 1;
    rd_req[1] += 1;
    s_axil_rready = '1;
    repeat (2) @(negedge clk);
    check("t6_hold_in_reset", hs_all, '0);
    log_idx.delete();
    log_wr.delete();
    rst = 1'b0;
    wait_idle("t6_done");
    check("t6_order", {log_idx.size(), pack_idx()}, {32'd2, 8'b10});
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
